// File: rtl/conv2_pkg.sv
// conv2_pkg: shared geometry and state encoding for the Convolution 2 layer
// (window read address generator, conv2_mem_write, layer controller).
package conv2_pkg;

  localparam int unsigned IMG_W  = 12;          // input map width/height
  localparam int unsigned K      = 5;           // kernel width/height
  localparam int unsigned OUT_W  = IMG_W - K + 1; // output map width/height (8)
  localparam int unsigned N_FILT = 3;           // filters / passes
  localparam int unsigned TAPS   = K * K;       // taps per window

  // Counter widths for the tap/position/filter counters
  localparam int unsigned KW_W   = $clog2(K);
  localparam int unsigned POS_W  = $clog2(OUT_W);
  localparam int unsigned FILT_W = $clog2(N_FILT);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/conv2_tap_counter.sv
// conv2_tap_counter: modulo-N counter with enable, synchronous clear and
// asynchronous active-high reset.
//   clk, reset  : clock, async reset (count -> 0)
//   i_en        : advance by one (wrapping N-1 -> 0)
//   i_clr       : synchronous clear, wins over i_en
//   o_count     : current count
//   o_wrap      : count is at N-1; the next enabled advance wraps. Used by
//                 the parent to enable the next-slower counter in a chain.
module conv2_tap_counter #(
  parameter int unsigned N = 5,
  parameter int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      if (o_wrap) r_count <= '0;
      else        r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_wrap  = (r_count == W'(N - 1));

endmodule

// File: rtl/conv2_window_read.sv
// conv2_window_read: Convolution 2 input-side address generator. Walks a
// KxK window over the IMG_W x IMG_W input map for every OUT_W x OUT_W output
// position and every filter, one tap per cycle.
//   clk, reset  : clock, async active-high reset
//   start       : begin a full layer pass (honoured in IDLE/DONE only)
//   stall       : hold traversal for this cycle
//   in_addr     : input map read address  (orow+kr)*IMG_W + (ocol+kc)
//   w_addr      : weight read address     f*K*K + kr*K + kc
//   addr_valid  : live tap this cycle
//   first_tap   : tap (0,0) of a window, qualified by addr_valid
//   last_tap    : tap (K-1,K-1) of a window, qualified by addr_valid
//   out_pos     : orow*OUT_W + ocol
//   filt        : current filter
//   busy / done : state RUN / state DONE (level)
module conv2_window_read
  import conv2_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned WADDR_W = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  output logic [ADDR_W-1:0]  in_addr,
  output logic [WADDR_W-1:0] w_addr,
  output logic               addr_valid,
  output logic               first_tap,
  output logic               last_tap,
  output logic [5:0]         out_pos,
  output logic [1:0]         filt,
  output logic               busy,
  output logic               done
);

  state_t r_state;
  state_t w_next;

  logic [KW_W-1:0]   w_kc, w_kr;
  logic [POS_W-1:0]  w_ocol, w_orow;
  logic [FILT_W-1:0] w_f;
  logic w_kc_wrap, w_kr_wrap, w_ocol_wrap, w_orow_wrap, w_f_wrap;
  logic w_final, w_clr, w_adv;
  logic w_en_kr, w_en_ocol, w_en_orow, w_en_f;

  // The final tap is presented by holding the counters rather than letting
  // them wrap, so addresses keep their final values through DONE.
  assign w_final = w_kc_wrap & w_kr_wrap & w_ocol_wrap & w_orow_wrap & w_f_wrap;
  assign w_clr   = start & (r_state != RUN);
  assign w_adv   = (r_state == RUN) & ~stall & ~w_final;

  assign w_en_kr   = w_adv     & w_kc_wrap;
  assign w_en_ocol = w_en_kr   & w_kr_wrap;
  assign w_en_orow = w_en_ocol & w_ocol_wrap;
  assign w_en_f    = w_en_orow & w_orow_wrap;

  conv2_tap_counter #(.N(K), .W(KW_W)) u_kc (
    .clk(clk), .reset(reset), .i_en(w_adv), .i_clr(w_clr),
    .o_count(w_kc), .o_wrap(w_kc_wrap)
  );
  conv2_tap_counter #(.N(K), .W(KW_W)) u_kr (
    .clk(clk), .reset(reset), .i_en(w_en_kr), .i_clr(w_clr),
    .o_count(w_kr), .o_wrap(w_kr_wrap)
  );
  conv2_tap_counter #(.N(OUT_W), .W(POS_W)) u_ocol (
    .clk(clk), .reset(reset), .i_en(w_en_ocol), .i_clr(w_clr),
    .o_count(w_ocol), .o_wrap(w_ocol_wrap)
  );
  conv2_tap_counter #(.N(OUT_W), .W(POS_W)) u_orow (
    .clk(clk), .reset(reset), .i_en(w_en_orow), .i_clr(w_clr),
    .o_count(w_orow), .o_wrap(w_orow_wrap)
  );
  conv2_tap_counter #(.N(N_FILT), .W(FILT_W)) u_f (
    .clk(clk), .reset(reset), .i_en(w_en_f), .i_clr(w_clr),
    .o_count(w_f), .o_wrap(w_f_wrap)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (!stall && w_final) w_next = DONE;
      DONE:    if (start) w_next = RUN;
      default: w_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy       = (r_state == RUN);
    done       = (r_state == DONE);
    addr_valid = busy & ~stall;
    first_tap  = addr_valid & (w_kc == '0) & (w_kr == '0);
    last_tap   = addr_valid & w_kc_wrap & w_kr_wrap;
  end

  // Address arithmetic from the registered counters
  always_comb begin
    in_addr = (ADDR_W'(w_orow) + ADDR_W'(w_kr)) * ADDR_W'(IMG_W)
            + ADDR_W'(w_ocol) + ADDR_W'(w_kc);
    w_addr  = WADDR_W'(w_f) * WADDR_W'(TAPS)
            + WADDR_W'(w_kr) * WADDR_W'(K) + WADDR_W'(w_kc);
    out_pos = {w_orow, w_ocol};
    filt    = w_f;
  end

endmodule

// File: tb/tb_conv2_window_read.sv
module tb_conv2_window_read;

  localparam int NTAP = 4800;

  logic       clk = 1'b0;
  logic       reset, start, stall;
  logic [7:0] in_addr;
  logic [6:0] w_addr;
  logic       addr_valid, first_tap, last_tap, busy, done;
  logic [5:0] out_pos;
  logic [1:0] filt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference tap sequence built from the window-walk rules
  int e_in[NTAP], e_w[NTAP], e_pos[NTAP], e_filt[NTAP];
  bit e_first[NTAP], e_last[NTAP];

  // Observations from the most recent pass, indexed by tap number
  int o_in[NTAP], o_w[NTAP], o_filt[NTAP];
  bit o_last[NTAP];
  int done_cyc, valid_cnt, stall_cnt;

  conv2_window_read #(.ADDR_W(8), .WADDR_W(7)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .in_addr(in_addr), .w_addr(w_addr), .addr_valid(addr_valid),
    .first_tap(first_tap), .last_tap(last_tap), .out_pos(out_pos),
    .filt(filt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic void build_model();
    int t = 0;
    for (int f = 0; f < 3; f++)
      for (int orow = 0; orow < 8; orow++)
        for (int ocol = 0; ocol < 8; ocol++)
          for (int kr = 0; kr < 5; kr++)
            for (int kc = 0; kc < 5; kc++) begin
              e_in[t]    = (orow + kr) * 12 + (ocol + kc);
              e_w[t]     = f * 25 + kr * 5 + kc;
              e_pos[t]   = orow * 8 + ocol;
              e_filt[t]  = f;
              e_first[t] = (kr == 0 && kc == 0);
              e_last[t]  = (kr == 4 && kc == 4);
              t++;
            end
  endfunction

  // One full layer pass from IDLE/DONE, checking every cycle against the model.
  // fix_tap/fix_len force a stall burst at a given tap; stall_pct/start_pct
  // add random stalls and ignored start pulses while running.
  task automatic run_pass(input int stall_pct, input int fix_tap,
                          input int fix_len, input int start_pct);
    int idx = 0;
    int cyc = 0;
    int fix_left = fix_len;
    bit st;
    bit fin = 1'b0;
    logic [27:0] got, exp;
    valid_cnt = 0; stall_cnt = 0; done_cyc = -1;
    start = 1'b1; stall = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    while (!fin && cyc < 20000) begin
      cyc++;
      if (idx < NTAP) begin
        if (idx == fix_tap && fix_left > 0) begin
          st = 1'b1; fix_left--;
        end else begin
          st = ($urandom_range(99) < stall_pct);
        end
        stall = st;
        start = ($urandom_range(99) < start_pct);
      end else begin
        st = 1'b0;
        stall = $urandom_range(1);
        start = 1'b0;
      end
      #1;
      got = {addr_valid, first_tap, last_tap, busy, done, in_addr, w_addr, out_pos, filt};
      if (idx < NTAP)
        exp = {~st, ~st & e_first[idx], ~st & e_last[idx], 1'b1, 1'b0,
               8'(e_in[idx]), 7'(e_w[idx]), 6'(e_pos[idx]), 2'(e_filt[idx])};
      else
        exp = {5'b00001, 8'd143, 7'd74, 6'd63, 2'd2};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL tap%0d cyc%0d {v,f,l,busy,done,in,w,pos,filt} got %b required %b",
                 idx, cyc, got, exp);
      end
      if (idx >= NTAP) begin
        fin = 1'b1;
        done_cyc = cyc;
      end else if (!st) begin
        o_in[idx] = int'(in_addr); o_w[idx] = int'(w_addr);
        o_filt[idx] = int'(filt); o_last[idx] = last_tap;
        idx++; valid_cnt++;
      end else begin
        stall_cnt++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; stall = 1'b0;
    n_tests++;
    if (!fin) begin
      n_fail++;
      $display("FAIL pass_timeout got taps=%0d required done after %0d taps", idx, NTAP);
    end
  endtask

  task automatic test_reset();
    logic [27:0] got;
    reset = 1'b1; start = 1'b0; stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    got = {addr_valid, first_tap, last_tap, busy, done, in_addr, w_addr, out_pos, filt};
    n_tests++;
    if (got !== '0) begin
      n_fail++; $display("FAIL reset_values got %b required 0", got);
    end
    reset = 1'b0;
    stall = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    got = {addr_valid, first_tap, last_tap, busy, done, in_addr, w_addr, out_pos, filt};
    n_tests++;
    if (got !== '0) begin
      n_fail++; $display("FAIL idle_stall got %b required 0", got);
    end
    stall = 1'b0;
  endtask

  task automatic test_nominal();
    run_pass(0, -1, 0, 0);
    n_tests++; if (valid_cnt !== NTAP) begin n_fail++; $display("FAIL nom_valid got %0d required %0d", valid_cnt, NTAP); end
    n_tests++; if (done_cyc !== 4801) begin n_fail++; $display("FAIL nom_done_cyc got %0d required 4801", done_cyc); end
    n_tests++; if (o_in[24] !== 52 || o_last[24] !== 1'b1) begin n_fail++; $display("FAIL tap24 got in=%0d last=%b required 52 1", o_in[24], o_last[24]); end
    n_tests++; if (o_in[25] !== 1 || o_w[25] !== 0) begin n_fail++; $display("FAIL tap25 got in=%0d w=%0d required 1 0", o_in[25], o_w[25]); end
    n_tests++; if (o_in[200] !== 12) begin n_fail++; $display("FAIL pos8_first got %0d required 12", o_in[200]); end
    n_tests++; if (o_in[63*25+24] !== 143) begin n_fail++; $display("FAIL pos63_last got %0d required 143", o_in[63*25+24]); end
    n_tests++; if (o_filt[1600] !== 1 || o_w[1600] !== 25 || o_in[1600] !== 0) begin
      n_fail++; $display("FAIL tap1600 got filt=%0d w=%0d in=%0d required 1 25 0", o_filt[1600], o_w[1600], o_in[1600]);
    end
    n_tests++; if (o_in[4799] !== 143 || o_w[4799] !== 74 || o_last[4799] !== 1'b1) begin
      n_fail++; $display("FAIL final_tap got in=%0d w=%0d last=%b required 143 74 1", o_in[4799], o_w[4799], o_last[4799]);
    end
  endtask

  task automatic test_start_in_done();
    int cyc = 0;
    int vcnt = 0;
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL pre_done got %b required 1", done); end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_tests++;
    if ({done, busy, addr_valid, first_tap, in_addr} !== {4'b0111, 8'd0}) begin
      n_fail++;
      $display("FAIL restart got done=%b busy=%b v=%b first=%b in=%0d required 0 1 1 1 0",
               done, busy, addr_valid, first_tap, in_addr);
    end
    while (done !== 1'b1 && cyc < 6000) begin
      if (addr_valid === 1'b1) vcnt++;
      @(posedge clk); #1;
      cyc++;
    end
    n_tests++; if (vcnt !== NTAP) begin n_fail++; $display("FAIL restart_valid got %0d required %0d", vcnt, NTAP); end
  endtask

  task automatic test_stall_tap10();
    run_pass(0, 10, 3, 0);
    n_tests++; if (stall_cnt !== 3) begin n_fail++; $display("FAIL s10_stalls got %0d required 3", stall_cnt); end
    n_tests++; if (valid_cnt !== NTAP) begin n_fail++; $display("FAIL s10_valid got %0d required %0d", valid_cnt, NTAP); end
    n_tests++; if (done_cyc !== 4804) begin n_fail++; $display("FAIL s10_done_cyc got %0d required 4804", done_cyc); end
  endtask

  task automatic test_final_stall();
    run_pass(0, NTAP - 1, 6, 0);
    n_tests++; if (done_cyc !== 4807) begin n_fail++; $display("FAIL fstall_done_cyc got %0d required 4807", done_cyc); end
    n_tests++; if (valid_cnt !== NTAP) begin n_fail++; $display("FAIL fstall_valid got %0d required %0d", valid_cnt, NTAP); end
  endtask

  task automatic test_random_stall();
    for (int r = 0; r < 2; r++) begin
      run_pass(25, -1, 0, 15);
      n_tests++; if (valid_cnt !== NTAP) begin n_fail++; $display("FAIL rnd%0d_valid got %0d required %0d", r, valid_cnt, NTAP); end
      n_tests++; if (done_cyc !== 4801 + stall_cnt) begin
        n_fail++; $display("FAIL rnd%0d_done_cyc got %0d required %0d", r, done_cyc, 4801 + stall_cnt);
      end
    end
  endtask

  task automatic test_reset_midrun();
    logic [27:0] got;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    got = {addr_valid, first_tap, last_tap, busy, done, in_addr, w_addr, out_pos, filt};
    n_tests++;
    if (got !== '0) begin n_fail++; $display("FAIL midrun_reset got %b required 0", got); end
    @(posedge clk); #1;
    got = {addr_valid, first_tap, last_tap, busy, done, in_addr, w_addr, out_pos, filt};
    n_tests++;
    if (got !== '0) begin n_fail++; $display("FAIL reset_held got %b required 0", got); end
    reset = 1'b0;
    @(posedge clk); #1;
    run_pass(10, -1, 0, 0);
    n_tests++; if (valid_cnt !== NTAP) begin n_fail++; $display("FAIL post_reset_valid got %0d required %0d", valid_cnt, NTAP); end
  endtask

  initial begin
    build_model();
    test_reset();
    test_nominal();
    test_start_in_done();
    test_stall_tap10();
    test_final_stall();
    test_random_stall();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
